regfile_sb: RTL and testbench



---
 rtl/regfile_sb_if.sv | 31 +++
 rtl/regfile_sb.sv | 88 ++++++++
 tb/tb_regfile_sb.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/regfile_sb_if.sv
// Decode/writeback-side bundle for the register file and its pending-write scoreboard.
// Latency: carries combinational read data and busy flags back to the decode stage.
// Backpressure: none on the bus itself; decode stalls on rdN_busy.
interface regfile_sb_if #(
    parameter int WIDTH = 32
);
    logic [4:0]       ra1;
    logic [4:0]       ra2;
    logic [WIDTH-1:0] rd1;
    logic [WIDTH-1:0] rd2;
    logic             we;
    logic [4:0]       wa;
    logic [WIDTH-1:0] wd;
    logic             issue;
    logic [4:0]       issue_dst;
    logic             rd1_busy;
    logic             rd2_busy;
    logic             sb_err;

    // Pipeline side: decode drives read addresses and issues, writeback drives the write port.
    modport master (
        output ra1, ra2, we, wa, wd, issue, issue_dst,
        input  rd1, rd2, rd1_busy, rd2_busy, sb_err
    );

    // Register file side.
    modport slave (
        input  ra1, ra2, we, wa, wd, issue, issue_dst,
        output rd1, rd2, rd1_busy, rd2_busy, sb_err
    );
endinterface

// File: rtl/regfile_sb.sv
// Register file (r0 hardwired to zero) with per-register 2-bit pending-write counters.
// Latency: reads and busy are combinational with write-through bypass; writes land 1 edge later.
// Backpressure: none; decode stalls on rdN_busy, protocol violations set sticky sb_err.
module regfile_sb #(
    parameter int WIDTH = 32,
    parameter int NREG  = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    regfile_sb_if.slave  bus
);
    logic [WIDTH-1:0] regs_q [NREG];
    logic [WIDTH-1:0] regs_d [NREG];
    logic [1:0]       cnt_q  [NREG];
    logic [1:0]       cnt_d  [NREG];
    logic             sb_err_q;
    logic             sb_err_d;

    logic [1:0]       ret1;
    logic [1:0]       ret2;

    // Next state of the array: a single write port, writes to r0 are discarded.
    always_comb begin
        regs_d = regs_q;
        if (bus.we && (bus.wa != 5'd0)) begin
            regs_d[bus.wa] = bus.wd;
        end
        regs_d[0] = '0;
    end

    // Scoreboard: issue increments, retire decrements, both together cancel; saturate and flag errors.
    always_comb begin
        cnt_d    = cnt_q;
        sb_err_d = sb_err_q;
        for (int r = 1; r < NREG; r++) begin
            if ((bus.issue && (bus.issue_dst == 5'(r))) && !(bus.we && (bus.wa == 5'(r)))) begin
                if (cnt_q[r] == 2'd3) begin
                    sb_err_d = 1'b1;
                end else begin
                    cnt_d[r] = cnt_q[r] + 2'd1;
                end
            end else if (!(bus.issue && (bus.issue_dst == 5'(r))) && (bus.we && (bus.wa == 5'(r)))) begin
                if (cnt_q[r] == 2'd0) begin
                    sb_err_d = 1'b1;
                end else begin
                    cnt_d[r] = cnt_q[r] - 2'd1;
                end
            end
        end
        cnt_d[0] = 2'd0;
    end

    // State registers; synchronous reset discards all in-flight state and overrides we/issue.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int r = 0; r < NREG; r++) begin
                regs_q[r] <= '0;
                cnt_q[r]  <= 2'd0;
            end
            sb_err_q <= 1'b0;
        end else begin
            for (int r = 0; r < NREG; r++) begin
                regs_q[r] <= regs_d[r];
                cnt_q[r]  <= cnt_d[r];
            end
            sb_err_q <= sb_err_d;
        end
    end

    // Operand reads with bypass, and busy that discounts a write retiring this very cycle.
    always_comb begin
        ret1 = {1'b0, bus.we && (bus.wa == bus.ra1)};
        ret2 = {1'b0, bus.we && (bus.wa == bus.ra2)};

        bus.rd1 = '0;
        if (bus.ra1 != 5'd0) begin
            bus.rd1 = (bus.we && (bus.wa == bus.ra1)) ? bus.wd : regs_q[bus.ra1];
        end
        bus.rd2 = '0;
        if (bus.ra2 != 5'd0) begin
            bus.rd2 = (bus.we && (bus.wa == bus.ra2)) ? bus.wd : regs_q[bus.ra2];
        end

        bus.rd1_busy = (bus.ra1 != 5'd0) && ((cnt_q[bus.ra1] - ret1) != 2'd0);
        bus.rd2_busy = (bus.ra2 != 5'd0) && ((cnt_q[bus.ra2] - ret2) != 2'd0);
        bus.sb_err   = sb_err_q;
    end
endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: reset, bypass, r0, load-use stall, WAW depth, issue/retire overlap.
// Inputs change 1ns after a rising edge; outputs are checked 1ns later, well away from the edge.
// Every expected value below is hand-computed from the register file behaviour.
module tb_regfile_sb;
    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_bad = 0;

    regfile_sb_if #(.WIDTH(32)) bus ();

    regfile_sb #(.WIDTH(32), .NREG(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.we = 1'b0; bus.wa = 5'd0; bus.wd = 32'd0;
        bus.issue = 1'b0; bus.issue_dst = 5'd0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle();
        bus.ra1 = 5'd5; bus.ra2 = 5'd31;
        tick();
        rst_n = 1'b1;
        #1;
        n_cmp++; if (bus.rd1 !== 32'd0) begin n_bad++; $display("FAIL reset_rd1: got %h want %h", bus.rd1, 32'd0); end
        n_cmp++; if (bus.rd2 !== 32'd0) begin n_bad++; $display("FAIL reset_rd2: got %h want %h", bus.rd2, 32'd0); end
        n_cmp++; if ({bus.rd1_busy, bus.rd2_busy} !== 2'b00) begin n_bad++; $display("FAIL reset_busy: got %b want 00", {bus.rd1_busy, bus.rd2_busy}); end
        n_cmp++; if (bus.sb_err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", bus.sb_err); end
    endtask

    task automatic test_write_bypass();
        // Issue first so the later retire is legal.
        bus.issue = 1'b1; bus.issue_dst = 5'd8;
        tick();
        bus.issue = 1'b0;
        bus.we = 1'b1; bus.wa = 5'd8; bus.wd = 32'hDEADBEEF;
        bus.ra1 = 5'd8; bus.ra2 = 5'd8;
        #1;
        n_cmp++; if (bus.rd1 !== 32'hDEADBEEF) begin n_bad++; $display("FAIL bypass_rd1: got %h want DEADBEEF", bus.rd1); end
        n_cmp++; if (bus.rd1_busy !== 1'b0) begin n_bad++; $display("FAIL bypass_busy: got %b want 0", bus.rd1_busy); end
        tick();
        idle();
        #1;
        n_cmp++; if (bus.rd1 !== 32'hDEADBEEF) begin n_bad++; $display("FAIL stored_rd1: got %h want DEADBEEF", bus.rd1); end
        n_cmp++; if (bus.rd2 !== 32'hDEADBEEF) begin n_bad++; $display("FAIL same_addr_rd2: got %h want DEADBEEF", bus.rd2); end
        n_cmp++; if (bus.rd2_busy !== 1'b0) begin n_bad++; $display("FAIL stored_busy: got %b want 0", bus.rd2_busy); end
    endtask

    task automatic test_reg0();
        bus.we = 1'b1; bus.wa = 5'd0; bus.wd = 32'hFFFFFFFF;
        bus.issue = 1'b1; bus.issue_dst = 5'd0;
        bus.ra1 = 5'd0;
        #1;
        n_cmp++; if (bus.rd1 !== 32'd0) begin n_bad++; $display("FAIL r0_bypass: got %h want 0", bus.rd1); end
        tick();
        idle();
        #1;
        n_cmp++; if (bus.rd1 !== 32'd0) begin n_bad++; $display("FAIL r0_rd1: got %h want 0", bus.rd1); end
        n_cmp++; if (bus.rd1_busy !== 1'b0) begin n_bad++; $display("FAIL r0_busy: got %b want 0", bus.rd1_busy); end
        n_cmp++; if (bus.sb_err !== 1'b0) begin n_bad++; $display("FAIL r0_err: got %b want 0", bus.sb_err); end
    endtask

    task automatic test_load_use();
        bus.ra2 = 5'd9;
        bus.issue = 1'b1; bus.issue_dst = 5'd9;
        #1;
        n_cmp++; if (bus.rd2_busy !== 1'b0) begin n_bad++; $display("FAIL lu_cycle0_busy: got %b want 0", bus.rd2_busy); end
        tick();
        idle();
        for (int c = 1; c <= 2; c++) begin
            #1;
            n_cmp++; if (bus.rd2_busy !== 1'b1) begin n_bad++; $display("FAIL lu_cycle%0d_busy: got %b want 1", c, bus.rd2_busy); end
            tick();
        end
        bus.we = 1'b1; bus.wa = 5'd9; bus.wd = 32'h00001234;
        #1;
        n_cmp++; if (bus.rd2_busy !== 1'b0) begin n_bad++; $display("FAIL lu_retire_busy: got %b want 0", bus.rd2_busy); end
        n_cmp++; if (bus.rd2 !== 32'h00001234) begin n_bad++; $display("FAIL lu_retire_rd2: got %h want 00001234", bus.rd2); end
        tick();
        idle();
        #1;
        n_cmp++; if (bus.rd2 !== 32'h00001234) begin n_bad++; $display("FAIL lu_after_rd2: got %h want 00001234", bus.rd2); end
        n_cmp++; if (bus.rd2_busy !== 1'b0) begin n_bad++; $display("FAIL lu_after_busy: got %b want 0", bus.rd2_busy); end
    endtask

    task automatic test_waw_depth();
        logic exp_busy [3];
        exp_busy[0] = 1'b1; exp_busy[1] = 1'b1; exp_busy[2] = 1'b0;
        bus.ra1 = 5'd3;
        for (int i = 0; i < 3; i++) begin
            bus.issue = 1'b1; bus.issue_dst = 5'd3;
            tick();
            #1;
            n_cmp++; if (bus.rd1_busy !== 1'b1) begin n_bad++; $display("FAIL waw_issue%0d_busy: got %b want 1", i, bus.rd1_busy); end
        end
        n_cmp++; if (bus.sb_err !== 1'b0) begin n_bad++; $display("FAIL waw_depth3_err: got %b want 0", bus.sb_err); end
        tick();
        idle();
        #1;
        n_cmp++; if (bus.sb_err !== 1'b1) begin n_bad++; $display("FAIL waw_overflow_err: got %b want 1", bus.sb_err); end
        // Counter held at 3, so the third retire is the first one that clears busy.
        for (int i = 0; i < 3; i++) begin
            bus.we = 1'b1; bus.wa = 5'd3; bus.wd = 32'h300 + 32'(i);
            #1;
            n_cmp++; if (bus.rd1_busy !== exp_busy[i]) begin n_bad++; $display("FAIL waw_retire%0d_busy: got %b want %b", i, bus.rd1_busy, exp_busy[i]); end
            tick();
        end
        idle();
        #1;
        n_cmp++; if (bus.rd1_busy !== 1'b0) begin n_bad++; $display("FAIL waw_drained_busy: got %b want 0", bus.rd1_busy); end
        n_cmp++; if (bus.rd1 !== 32'h302) begin n_bad++; $display("FAIL waw_last_data: got %h want 00000302", bus.rd1); end
    endtask

    task automatic test_issue_retire_reset();
        bus.ra1 = 5'd4;
        bus.issue = 1'b1; bus.issue_dst = 5'd4;
        tick();
        bus.we = 1'b1; bus.wa = 5'd4; bus.wd = 32'h55;
        tick();
        idle();
        #1;
        n_cmp++; if (bus.rd1_busy !== 1'b1) begin n_bad++; $display("FAIL overlap_busy: got %b want 1", bus.rd1_busy); end
        n_cmp++; if (bus.rd1 !== 32'h55) begin n_bad++; $display("FAIL overlap_rd1: got %h want 00000055", bus.rd1); end
        n_cmp++; if (bus.sb_err !== 1'b1) begin n_bad++; $display("FAIL sticky_err: got %b want 1", bus.sb_err); end
        rst_n = 1'b0;
        bus.we = 1'b1; bus.wa = 5'd4; bus.wd = 32'hAAAA;
        #1;
        n_cmp++; if (bus.rd1 !== 32'hAAAA) begin n_bad++; $display("FAIL rst_bypass_rd1: got %h want 0000AAAA", bus.rd1); end
        tick();
        rst_n = 1'b1;
        idle();
        #1;
        n_cmp++; if (bus.rd1 !== 32'd0) begin n_bad++; $display("FAIL rst_reg4: got %h want 0", bus.rd1); end
        n_cmp++; if (bus.rd1_busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b want 0", bus.rd1_busy); end
        n_cmp++; if (bus.sb_err !== 1'b0) begin n_bad++; $display("FAIL rst_err: got %b want 0", bus.sb_err); end
    endtask

    task automatic test_underflow();
        bus.ra2 = 5'd6;
        bus.we = 1'b1; bus.wa = 5'd6; bus.wd = 32'h66;
        tick();
        idle();
        #1;
        n_cmp++; if (bus.sb_err !== 1'b1) begin n_bad++; $display("FAIL underflow_err: got %b want 1", bus.sb_err); end
        n_cmp++; if (bus.rd2_busy !== 1'b0) begin n_bad++; $display("FAIL underflow_busy: got %b want 0", bus.rd2_busy); end
        n_cmp++; if (bus.rd2 !== 32'h66) begin n_bad++; $display("FAIL underflow_rd2: got %h want 00000066", bus.rd2); end
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        bus.ra1 = 5'd0; bus.ra2 = 5'd0;
        tick();
        test_reset();
        test_write_bypass();
        test_reg0();
        test_load_use();
        test_waw_depth();
        test_issue_retire_reset();
        test_underflow();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
